// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit: the fetch FSM state
// type, the datapath word width, and the default reset PC / halt opcode
// used as parameter defaults by fetch_unit.
// No ports (package).
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int WORD_W = 32;

    // "init" address: one word below zero, so the first fetch after start
    // lands on address 0 (RESET_PC + 4 wraps modulo 2^32).
    localparam logic [WORD_W-1:0] RESET_PC = 32'hFFFF_FFFC;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch unit's control inputs, instruction-memory bus and IF
// register outputs.
//   master : the fetch unit (drives pc_out and the IF register outputs)
//   slave  : the surroundings (memory + pipeline control)
// Signals:
//   start, stall, redirect_valid, redirect_target, instr_in  -> into fetch
//   pc_out, if_valid, if_pc, if_instr, halted                -> out of fetch
//   fetch_count (only with FETCH_PERF_COUNT_EN defined)      -> out of fetch
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              start;
    logic              stall;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_target;
    logic [WORD_W-1:0] instr_in;
    logic [WORD_W-1:0] pc_out;
    logic              if_valid;
    logic [WORD_W-1:0] if_pc;
    logic [WORD_W-1:0] if_instr;
    logic              halted;
`ifdef FETCH_PERF_COUNT_EN
    logic [WORD_W-1:0] fetch_count;
`endif

    modport master (
        input  start, stall, redirect_valid, redirect_target, instr_in,
`ifdef FETCH_PERF_COUNT_EN
        output fetch_count,
`endif
        output pc_out, if_valid, if_pc, if_instr, halted
    );

    modport slave (
        output start, stall, redirect_valid, redirect_target, instr_in,
`ifdef FETCH_PERF_COUNT_EN
        input  fetch_count,
`endif
        input  pc_out, if_valid, if_pc, if_instr, halted
    );

endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Single-stage instruction fetch: PC register, INIT/RUN/HALT FSM and the IF
// pipeline register. Instruction memory is combinational (instr_in answers
// pc_out in the same cycle), so an instruction appears in the IF register
// one cycle after its address is on pc_out.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fetch_unit_if.master (see fetch_unit_if.sv)
// Parameters: RESET_PC, IMEM_SIZE (words), HALT_OPCODE.
// Optional feature: define FETCH_PERF_COUNT_EN to add the fetch_count
// performance counter (counts instructions captured into the IF register).
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = fetch_unit_pkg::RESET_PC,
    parameter int unsigned IMEM_SIZE   = 128,
    parameter logic [5:0]  HALT_OPCODE = fetch_unit_pkg::HALT_OPCODE
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    import fetch_unit_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [WORD_W-1:0] if_pc_q, if_pc_d;
    logic [WORD_W-1:0] if_instr_q, if_instr_d;
    logic              capture;
    logic              out_of_range;
    logic              is_halt_op;

    assign out_of_range = {2'b00, pc_q[WORD_W-1:2]} >= IMEM_SIZE;
    assign is_halt_op   = bus.instr_in[31:26] == HALT_OPCODE;

    // Next-state logic. Priority inside RUN: redirect beats stall (a taken
    // branch must never be lost), stall beats everything else, and running
    // off the end of memory halts without capturing the garbage word.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        capture    = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (bus.start) begin
                    pc_d    = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    // Masking keeps the fetch word-aligned and consumes all
                    // target bits.
                    pc_d       = bus.redirect_target & ~32'h3;
                    if_valid_d = 1'b0;
                end else if (bus.stall) begin
                    // hold everything
                end else if (out_of_range) begin
                    state_d    = ST_HALT;
                    if_valid_d = 1'b0;
                end else begin
                    capture    = 1'b1;
                    if_instr_d = bus.instr_in;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    // The halt instruction itself is forwarded; fetch stops
                    // on its address.
                    if (is_halt_op) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            ST_HALT: begin
                // Keep the last instruction visible until downstream takes it.
                if (!bus.stall) begin
                    if_valid_d = 1'b0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= {HALT_OPCODE, 26'b0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [WORD_W-1:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (capture) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.fetch_count = fetch_count_q;
`endif

    assign bus.pc_out   = pc_q;
    assign bus.if_valid = if_valid_q;
    assign bus.if_pc    = if_pc_q;
    assign bus.if_instr = if_instr_q;
    assign bus.halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed-vector bench for fetch_unit. Each vector drives inputs for one
// clock and queues the hand-computed register state expected after that
// edge; an independent monitor pops and compares on every falling edge.
// A behavioural 128-word memory answers pc_out combinationally.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RP = 32'hFFFF_FFFC;
    localparam logic [31:0] HI = 32'hFC00_0000;
    localparam logic [31:0] IA = 32'h0000_0A0A;
    localparam logic [31:0] IB = 32'h0000_0B0B;
    localparam logic [31:0] IC = 32'h0000_0C0C;
    localparam logic [31:0] ID = 32'h0000_0D0D;
    localparam logic [31:0] IE = 32'h0000_0E0E;
    localparam logic [31:0] IF = 32'h0000_0F0F;
    localparam logic [31:0] IG = 32'h1234_5678;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        v;
        logic [31:0] ipc;
        logic [31:0] ins;
        logic        h;
        int          fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] mem [0:127];

    always #5 clk = ~clk;

    fetch_unit_if fu_if();

    fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fu_if)
    );

    // Words beyond the 128-word memory read as a recognisable junk value.
    assign fu_if.instr_in = (fu_if.pc_out[31:9] == 23'd0) ? mem[fu_if.pc_out[8:2]]
                                                          : 32'hDEAD_BEEF;

    // Compare every field of the DUT's visible state against one expectation.
    task automatic checkOutput(input exp_t e);
        bit bad;
        bad = 0;
        vectors++;
        if (fu_if.pc_out !== e.pc) begin
            $display("[TB] FAIL %s pc_out: got %h want %h", e.tag, fu_if.pc_out, e.pc);
            bad = 1;
        end
        if (fu_if.if_valid !== e.v) begin
            $display("[TB] FAIL %s if_valid: got %b want %b", e.tag, fu_if.if_valid, e.v);
            bad = 1;
        end
        if (fu_if.if_pc !== e.ipc) begin
            $display("[TB] FAIL %s if_pc: got %h want %h", e.tag, fu_if.if_pc, e.ipc);
            bad = 1;
        end
        if (fu_if.if_instr !== e.ins) begin
            $display("[TB] FAIL %s if_instr: got %h want %h", e.tag, fu_if.if_instr, e.ins);
            bad = 1;
        end
        if (fu_if.halted !== e.h) begin
            $display("[TB] FAIL %s halted: got %b want %b", e.tag, fu_if.halted, e.h);
            bad = 1;
        end
`ifdef FETCH_PERF_COUNT_EN
        if (e.fc >= 0 && fu_if.fetch_count !== 32'(e.fc)) begin
            $display("[TB] FAIL %s fetch_count: got %0d want %0d", e.tag, fu_if.fetch_count, e.fc);
            bad = 1;
        end
`endif
        if (bad) miscompares++;
    endtask

    // Monitor: one expectation per falling edge, decoupled from stimulus.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            checkOutput(sb.pop_front());
        end
    end

    task automatic pushExp(input string tag, input logic [31:0] pc, input logic v,
                           input logic [31:0] ipc, input logic [31:0] ins,
                           input logic h, input int fc);
        exp_t e;
        e.tag = tag; e.pc = pc; e.v = v; e.ipc = ipc; e.ins = ins; e.h = h; e.fc = fc;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs; queue the state expected after the edge.
    task automatic applyStimulus(input string tag, input logic st, input logic sl,
                                 input logic rv, input logic [31:0] rt,
                                 input logic [31:0] e_pc, input logic e_v,
                                 input logic [31:0] e_ipc, input logic [31:0] e_ins,
                                 input logic e_h, input int e_fc);
        fu_if.start           = st;
        fu_if.stall           = sl;
        fu_if.redirect_valid  = rv;
        fu_if.redirect_target = rt;
        @(posedge clk);
        pushExp(tag, e_pc, e_v, e_ipc, e_ins, e_h, e_fc);
        @(negedge clk);
    endtask

    task automatic idleInputs();
        fu_if.start           = 1'b0;
        fu_if.stall           = 1'b0;
        fu_if.redirect_valid  = 1'b0;
        fu_if.redirect_target = 32'h0;
    endtask

    task automatic doReset(input string tag);
        idleInputs();
        rst_n = 1'b0;
        @(posedge clk);
        pushExp(tag, RP, 1'b0, 32'h0, HI, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset asserted between edges: the check lands before any further
    // rising edge, so only an asynchronous reset can satisfy it.
    task automatic asyncReset(input string tag);
        idleInputs();
        fu_if.stall = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        pushExp(tag, RP, 1'b0, 32'h0, HI, 1'b0, 0);
        @(negedge clk);
        @(posedge clk);
        pushExp({tag, "_hold"}, RP, 1'b0, 32'h0, HI, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idleInputs();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0] = IA; mem[1] = IB; mem[2] = IC; mem[3] = ID;
        mem[8] = IE; mem[9] = IF; mem[127] = IG;

        // Phase A: init, sequential fetch, stall, redirect, boundary word.
        $display("[TB] phase A: fetch, stall, redirect");
        doReset("rstA");
        for (int i = 0; i < 5; i++)
            applyStimulus("init_idle", 0, 0, 0, 32'h0, RP, 0, 32'h0, HI, 0, -1);
        applyStimulus("start",      1, 0, 0, 32'h0,    32'h0,   0, 32'h0,   HI, 0, 0);
        applyStimulus("capA",       0, 0, 0, 32'h0,    32'h4,   1, 32'h0,   IA, 0, 1);
        applyStimulus("capB",       0, 0, 0, 32'h0,    32'h8,   1, 32'h4,   IB, 0, 2);
        for (int i = 0; i < 3; i++)
            applyStimulus("stall",  0, 1, 0, 32'h0,    32'h8,   1, 32'h4,   IB, 0, 2);
        applyStimulus("capC",       0, 0, 0, 32'h0,    32'hC,   1, 32'h8,   IC, 0, 3);
        applyStimulus("capD",       0, 0, 0, 32'h0,    32'h10,  1, 32'hC,   ID, 0, 4);
        applyStimulus("redir_stl",  0, 1, 1, 32'h23,   32'h20,  0, 32'hC,   ID, 0, 4);
        applyStimulus("capE",       0, 0, 0, 32'h0,    32'h24,  1, 32'h20,  IE, 0, 5);
        applyStimulus("start_ign",  1, 0, 0, 32'h0,    32'h28,  1, 32'h24,  IF, 0, 6);
        applyStimulus("redir_1fe",  0, 0, 1, 32'h1FE,  32'h1FC, 0, 32'h24,  IF, 0, 6);
        applyStimulus("cap_last",   0, 0, 0, 32'h0,    32'h200, 1, 32'h1FC, IG, 0, 7);
        asyncReset("async_rst");

        // Phase B: halt opcode at word 3.
        $display("[TB] phase B: halt opcode");
        mem[3] = HI;
        doReset("rstB");
        applyStimulus("startB",     0 | 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, HI, 0, 0);
        applyStimulus("capA_B",     0, 0, 0, 32'h0,    32'h4,   1, 32'h0,   IA, 0, 1);
        applyStimulus("capB_B",     0, 0, 0, 32'h0,    32'h8,   1, 32'h4,   IB, 0, 2);
        applyStimulus("capC_B",     0, 0, 0, 32'h0,    32'hC,   1, 32'h8,   IC, 0, 3);
        applyStimulus("cap_halt",   0, 0, 0, 32'h0,    32'hC,   1, 32'hC,   HI, 1, 4);
        applyStimulus("halt_stall", 0, 1, 0, 32'h0,    32'hC,   1, 32'hC,   HI, 1, 4);
        applyStimulus("halt_drop",  0, 0, 0, 32'h0,    32'hC,   0, 32'hC,   HI, 1, 4);
        applyStimulus("halt_ign",   1, 0, 1, 32'h40,   32'hC,   0, 32'hC,   HI, 1, 4);
        applyStimulus("halt_hold",  0, 0, 0, 32'h0,    32'hC,   0, 32'hC,   HI, 1, 4);

        // Phase C: redirect past the end of memory halts with no capture.
        $display("[TB] phase C: out-of-range redirect");
        mem[3] = ID;
        doReset("rstC");
        applyStimulus("startC",     1, 0, 0, 32'h0,    32'h0,   0, 32'h0,   HI, 0, 0);
        applyStimulus("capA_C",     0, 0, 0, 32'h0,    32'h4,   1, 32'h0,   IA, 0, 1);
        applyStimulus("capB_C",     0, 0, 0, 32'h0,    32'h8,   1, 32'h4,   IB, 0, 2);
        applyStimulus("redir_200",  0, 0, 1, 32'h200,  32'h200, 0, 32'h4,   IB, 0, 2);
        applyStimulus("oor_halt",   0, 0, 0, 32'h0,    32'h200, 0, 32'h4,   IB, 1, 2);
        applyStimulus("oor_hold",   0, 0, 0, 32'h0,    32'h200, 0, 32'h4,   IB, 1, 2);

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hFFFFFFFC, PC value held in INIT (memory "init" address).
REQ-002 SHALL have parameter IMEM_SIZE, default 128, instruction-memory depth in words.
REQ-003 SHALL have parameter HALT_OPCODE, default 6'b111111, opcode that ends fetch.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset is asynchronous and active-low.
REQ-006 start  input  1  leave INIT and begin fetching at address 0.
REQ-007 stall  input  1  downstream not ready; freeze PC and IF register.
REQ-008 redirect_valid  input  1  branch/jump taken this cycle.
REQ-009 redirect_target  input  32  byte address of redirect.
REQ-010 instr_in  input  32  combinational instruction-memory data for pc_out.
REQ-011 pc_out  output  32  byte address driven to instruction memory.
REQ-012 if_valid  output  1  IF register holds a live instruction.
REQ-013 if_pc  output  32  address of instruction in IF register.
REQ-014 if_instr  output  32  instruction in IF register.
REQ-015 halted  output  1  high while state is HALT.

Function
REQ-016 SHALL implement states INIT, RUN, HALT; STALL is a condition within RUN, not a state.
REQ-017 INIT: pc_out = RESET_PC, if_valid = 0; start=1 -> pc_out = 0 and RUN next cycle (RESET_PC+4 wraps mod 2^32).
REQ-018 RUN, no stall, no redirect: next cycle if_instr <= instr_in, if_pc <= pc_out, if_valid <= 1, pc_out <= pc_out+4 (one-cycle latency).
REQ-019 RUN, stall=1, no redirect: pc_out, if_pc, if_instr, if_valid unchanged.
REQ-020 redirect_valid=1 in RUN SHALL win over stall: pc_out <= {redirect_target[31:2],2'b00}, if_valid <= 0 (squash).
REQ-021 RUN, no stall, no redirect, instr_in[31:26] == HALT_OPCODE: capture as REQ-018 (halt forwarded, valid), pc_out held, state <= HALT.
REQ-022 RUN, (pc_out>>2) >= IMEM_SIZE: state <= HALT, if_valid <= 0, nothing captured.
REQ-023 HALT: pc_out held, if_valid <= 0 once not stalled, halted = 1; start, redirect ignored; exit only by reset.
REQ-024 start while in RUN or HALT SHALL be ignored.

Reset
REQ-025 rst_n=0 SHALL immediately force: state INIT, pc_out = RESET_PC, if_valid = 0, if_pc = 0, if_instr = {HALT_OPCODE,26'b0}, halted = 0, fetch_count = 0.
REQ-026 Reset mid-RUN or mid-stall SHALL discard in-flight IF contents; release waits for start.

Configuration
REQ-027 With FETCH_PERF_COUNT_EN defined: output fetch_count (32) increments by 1 on each REQ-018/REQ-021 capture, wraps at 2^32, holds otherwise.
REQ-028 Without FETCH_PERF_COUNT_EN: port fetch_count and its counter absent; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold the state enum (INIT/RUN/HALT), HALT_OPCODE, RESET_PC and the 32-bit word width constant.
REQ-030 Single module; no sub-module (PC register, FSM and IF register fit one block).

Verification
REQ-031 Reset, no start for 5 cycles -> pc_out = 32'hFFFFFFFC, if_valid = 0; start pulse -> pc_out = 0 next cycle, then 4, 8.
REQ-032 Memory words at 0,4,8 = A,B,C -> if_instr A,B,C on consecutive cycles with if_pc 0,4,8, if_valid = 1.
REQ-033 stall=1 for 3 cycles at pc_out = 8 -> pc_out, if_pc, if_instr frozen; release -> fetch resumes at 8 without loss/duplication.
REQ-034 stall=1 and redirect_valid=1, target 32'h00000023 -> pc_out = 32'h20 next cycle, if_valid = 0.
REQ-035 Word at 12 = 32'hFC000000 -> if_instr = 32'hFC000000 valid once, halted = 1, pc_out stays 12, later redirect ignored.
REQ-036 Redirect to 32'h200 (word 128, IMEM_SIZE=128) -> HALT with no capture; with FETCH_PERF_COUNT_EN, fetch_count equals captured count.
